traffic_controller: RTL and testbench

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

---
 rtl/traffic_controller.sv | 195 +++++++++++++++++++
 tb/tb_traffic_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_controller.sv
// ---------------------------------------------------------------------------
// traffic_controller
//   Two-road intersection sequencer. The main road rests on green until a
//   side-road request has been latched and the minimum green dwell has
//   elapsed, then cycles through main yellow, all-red, side green, side
//   yellow and all-red before returning. A level-sensitive night mode
//   flashes main yellow / side red until released into an all-red clearance.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset (forces RED2 clearance)
//   side_req    in   side-road vehicle sensor, sampled every edge
//   flash_en    in   night flash mode request, level-sensitive
//   light_main  out  [2:0] registered main lamps: red 100, green 010,
//                    yellow 001, dark 000
//   light_side  out  [2:0] registered side lamps, same encoding
//   phase       out  [2:0] registered state code
// ---------------------------------------------------------------------------
module traffic_controller #(
  parameter int unsigned GREEN_TIME  = 8,
  parameter int unsigned SIDE_TIME   = 4,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned FLASH_TIME  = 3,
  parameter int unsigned TIMER_W     = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       flash_en,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic [2:0] phase
);

  // State codes are visible on the phase output, so they stay fixed values.
  localparam logic [2:0] S_MAIN_G = 3'd0;
  localparam logic [2:0] S_MAIN_Y = 3'd1;
  localparam logic [2:0] S_RED1   = 3'd2;
  localparam logic [2:0] S_SIDE_G = 3'd3;
  localparam logic [2:0] S_SIDE_Y = 3'd4;
  localparam logic [2:0] S_RED2   = 3'd5;
  localparam logic [2:0] S_FLASH  = 3'd6;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  // Reload values: a state lasting N cycles starts its down-counter at N-1.
  localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_TIME  - 1);
  localparam logic [TIMER_W-1:0] T_SIDE   = TIMER_W'(SIDE_TIME   - 1);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] T_FLASH  = TIMER_W'(FLASH_TIME  - 1);

  logic [2:0]         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_req;
  logic               r_lit;
  logic [2:0]         r_light_main;
  logic [2:0]         r_light_side;

  logic [2:0]         w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_req_nxt;
  logic               w_lit_nxt;
  logic               w_timer_zero;
  logic [2:0]         w_main_nxt;
  logic [2:0]         w_side_nxt;

  assign w_timer_zero = (r_timer == '0);

  // Next-state / timer. The default timer path counts down and parks at 0,
  // which is what holds MAIN_G indefinitely without a request.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_timer_zero ? '0 : (r_timer - TIMER_W'(1));
    w_lit_nxt   = r_lit;

    case (r_state)
      S_MAIN_G: begin
        if (w_timer_zero && r_req) begin
          w_state_nxt = S_MAIN_Y;
          w_timer_nxt = T_YELLOW;
        end
      end
      S_MAIN_Y: begin
        if (w_timer_zero) begin
          w_state_nxt = S_RED1;
          w_timer_nxt = T_ALLRED;
        end
      end
      S_RED1: begin
        if (w_timer_zero) begin
          w_state_nxt = S_SIDE_G;
          w_timer_nxt = T_SIDE;
        end
      end
      S_SIDE_G: begin
        if (w_timer_zero) begin
          w_state_nxt = S_SIDE_Y;
          w_timer_nxt = T_YELLOW;
        end
      end
      S_SIDE_Y: begin
        if (w_timer_zero) begin
          w_state_nxt = S_RED2;
          w_timer_nxt = T_ALLRED;
        end
      end
      S_RED2: begin
        if (w_timer_zero) begin
          w_state_nxt = S_MAIN_G;
          w_timer_nxt = T_GREEN;
        end
      end
      S_FLASH: begin
        if (!flash_en) begin
          w_state_nxt = S_RED2;
          w_timer_nxt = T_ALLRED;
          w_lit_nxt   = 1'b1;
        end else if (w_timer_zero) begin
          w_timer_nxt = T_FLASH;
          w_lit_nxt   = ~r_lit;
        end
      end
      default: begin
        w_state_nxt = S_RED2;
        w_timer_nxt = T_ALLRED;
        w_lit_nxt   = 1'b1;
      end
    endcase

    // Flash request overrides every sequenced transition of a legal state.
    if (flash_en && (r_state <= S_RED2)) begin
      w_state_nxt = S_FLASH;
      w_timer_nxt = T_FLASH;
      w_lit_nxt   = 1'b1;
    end
  end

  // The latch is cleared on SIDE_G entry; a request on that same edge is lost.
  always_comb begin
    if ((w_state_nxt == S_SIDE_G) && (r_state != S_SIDE_G)) begin
      w_req_nxt = 1'b0;
    end else begin
      w_req_nxt = r_req | side_req;
    end
  end

  // Lamps are decoded from the next state so they register on the same edge
  // as the state itself and never lag it by a cycle.
  always_comb begin
    w_main_nxt = LAMP_RED;
    w_side_nxt = LAMP_RED;
    case (w_state_nxt)
      S_MAIN_G: w_main_nxt = LAMP_GREEN;
      S_MAIN_Y: w_main_nxt = LAMP_YELLOW;
      S_SIDE_G: w_side_nxt = LAMP_GREEN;
      S_SIDE_Y: w_side_nxt = LAMP_YELLOW;
      S_FLASH: begin
        w_main_nxt = w_lit_nxt ? LAMP_YELLOW : LAMP_DARK;
        w_side_nxt = w_lit_nxt ? LAMP_RED    : LAMP_DARK;
      end
      default: begin
        w_main_nxt = LAMP_RED;
        w_side_nxt = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RED2;
      r_timer      <= T_ALLRED;
      r_req        <= 1'b0;
      r_lit        <= 1'b1;
      r_light_main <= LAMP_RED;
      r_light_side <= LAMP_RED;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_req        <= w_req_nxt;
      r_lit        <= w_lit_nxt;
      r_light_main <= w_main_nxt;
      r_light_side <= w_side_nxt;
    end
  end

  assign light_main = r_light_main;
  assign light_side = r_light_side;
  assign phase      = r_state;

endmodule

// File: tb/tb_traffic_controller.sv
// ---------------------------------------------------------------------------
// tb_traffic_controller
//   Directed scenarios plus randomized side_req / flash_en traffic, checked
//   every cycle against a phase-table reference model that counts elapsed
//   cycles per phase.
// ---------------------------------------------------------------------------
module tb_traffic_controller;

  localparam int GREEN_TIME  = 8;
  localparam int SIDE_TIME   = 4;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int FLASH_TIME  = 3;

  logic       clock;
  logic       reset_n;
  logic       side_req;
  logic       flash_en;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic [2:0] phase;

  traffic_controller #(
    .GREEN_TIME (GREEN_TIME),
    .SIDE_TIME  (SIDE_TIME),
    .YELLOW_TIME(YELLOW_TIME),
    .ALLRED_TIME(ALLRED_TIME),
    .FLASH_TIME (FLASH_TIME),
    .TIMER_W    (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .side_req  (side_req),
    .flash_en  (flash_en),
    .light_main(light_main),
    .light_side(light_side),
    .phase     (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase index 0..5 is the normal ring, 6 is flash.
  int dwell    [6] = '{GREEN_TIME, YELLOW_TIME, ALLRED_TIME, SIDE_TIME, YELLOW_TIME, ALLRED_TIME};
  int main_tab [6] = '{2, 1, 4, 4, 4, 4};
  int side_tab [6] = '{4, 4, 4, 2, 1, 4};
  int m_phase;
  int m_elapsed;
  bit m_req;
  bit m_lit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 5;
    m_elapsed = 0;
    m_req     = 1'b0;
    m_lit     = 1'b1;
  endtask

  task automatic model_step(input bit sr, input bit fe);
    bit done;
    if (m_phase != 6 && fe) begin
      m_phase = 6; m_elapsed = 0; m_lit = 1'b1; m_req = m_req | sr;
    end else if (m_phase == 6 && !fe) begin
      m_phase = 5; m_elapsed = 0; m_lit = 1'b1; m_req = m_req | sr;
    end else if (m_phase == 6) begin
      m_elapsed++;
      if (m_elapsed == FLASH_TIME) begin
        m_lit = !m_lit;
        m_elapsed = 0;
      end
      m_req = m_req | sr;
    end else begin
      m_elapsed++;
      done = (m_elapsed >= dwell[m_phase]);
      if (m_phase == 0) done = done && m_req;
      if (done) begin
        m_phase   = (m_phase + 1) % 6;
        m_elapsed = 0;
      end
      if (done && m_phase == 3) m_req = 1'b0;
      else                      m_req = m_req | sr;
    end
  endtask

  task automatic check_all(input string tag);
    int em, es;
    if (m_phase == 6) begin
      em = m_lit ? 1 : 0;
      es = m_lit ? 4 : 0;
    end else begin
      em = main_tab[m_phase];
      es = side_tab[m_phase];
    end
    check({tag, ".phase"}, 32'(phase), 32'(m_phase));
    check({tag, ".main"}, 32'(light_main), 32'(em));
    check({tag, ".side"}, 32'(light_side), 32'(es));
    check({tag, ".nogreen"}, 32'(light_main[1] && light_side[1]), 32'd0);
    check({tag, ".main1hot"}, 32'($onehot0(light_main)), 32'd1);
    check({tag, ".side1hot"}, 32'($onehot0(light_side)), 32'd1);
  endtask

  task automatic do_cycle(input string tag, input bit sr, input bit fe);
    side_req = sr;
    flash_en = fe;
    @(posedge clock);
    model_step(sr, fe);
    @(negedge clock);
    check_all(tag);
  endtask

  // Assert reset between edges and confirm outputs change with no edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".imm"});
    side_req = 1'b0;
    flash_en = 1'b0;
    @(negedge clock);
    check_all({tag, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    bit sr, fe;
    int guard;
    reset_n  = 1'b0;
    side_req = 1'b0;
    flash_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    // Idle: RED2 for one cycle, then MAIN_G held.
    for (int i = 0; i < 20; i++) do_cycle("idle", 1'b0, 1'b0);

    // Single request pulse during MAIN_G.
    async_reset("rst2");
    for (int i = 0; i < 3; i++) do_cycle("pre", 1'b0, 1'b0);
    do_cycle("pulse", 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) do_cycle("post", 1'b0, 1'b0);

    // Request held high: 18-cycle ring.
    for (int i = 0; i < 40; i++) do_cycle("held", 1'b1, 1'b0);

    // Flash raised during SIDE_G.
    guard = 0;
    while (m_phase != 3 && guard < 60) begin
      do_cycle("to_sideg", 1'b1, 1'b0);
      guard++;
    end
    check("wait_side_g", 32'(m_phase), 32'd3);
    for (int i = 0; i < 8; i++) do_cycle("flash", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) do_cycle("unflash", 1'b0, 1'b0);

    // Asynchronous reset in the middle of SIDE_Y.
    guard = 0;
    while (m_phase != 4 && guard < 60) begin
      do_cycle("to_sidey", 1'b1, 1'b0);
      guard++;
    end
    check("wait_side_y", 32'(m_phase), 32'd4);
    async_reset("rst_sidey");
    for (int i = 0; i < 4; i++) do_cycle("after_sidey", 1'b0, 1'b0);

    // Asynchronous reset while flashing.
    for (int i = 0; i < 4; i++) do_cycle("flash2", 1'b1, 1'b1);
    async_reset("rst_flash");
    for (int i = 0; i < 4; i++) do_cycle("after_flash", 1'b0, 1'b0);

    // Randomized traffic.
    fe = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 79) == 0) fe = !fe;
      do_cycle("rand", sr, fe);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
